// File: rtl/registro_chamadas_pkg.sv
// Shared elevator types: direction of travel and the floor-count ceiling.
package pkg_elevador;

    localparam int unsigned N_ANDARES_MAX = 16;

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        SUBINDO  = 2'b01,
        DESCENDO = 2'b10
    } direction_t;

endpackage

// File: rtl/registro_chamadas_seletor.sv
// Combinational search over the pending-call vector relative to the car's floor.
module seletor_proximo_andar #(
    parameter int unsigned N_ANDARES = 4,
    parameter int unsigned W_END     = $clog2(N_ANDARES)
) (
    input  logic [N_ANDARES-1:0] chamadas,
    input  logic [W_END-1:0]     andar_atual,
    output logic                 acima,
    output logic                 abaixo,
    output logic                 aqui,
    output logic [W_END-1:0]     menor_acima,
    output logic [W_END-1:0]     maior_abaixo
);

    localparam int NA = int'(N_ANDARES);

    always_comb begin
        int atual;
        atual        = int'(andar_atual);
        acima        = 1'b0;
        abaixo       = 1'b0;
        aqui         = 1'b0;
        menor_acima  = '0;
        maior_abaixo = '0;
        // Ascending scan: the last hit at or below the floor is the highest one.
        for (int i = 0; i < NA; i++) begin
            if (chamadas[i]) begin
                if (i > atual) acima = 1'b1;
                if (i < atual) abaixo = 1'b1;
                if (i == atual) aqui = 1'b1;
                if (i <= atual) maior_abaixo = W_END'(i);
            end
        end
        for (int i = NA - 1; i >= 0; i--) begin
            if (chamadas[i] && (i >= atual)) menor_acima = W_END'(i);
        end
    end

endmodule

// File: rtl/registro_chamadas.sv
// Floor-call register bank with addressed read/write port and SCAN direction scheduler.
module registro_chamadas
    import pkg_elevador::*;
#(
    parameter int unsigned N_ANDARES = 4,
    parameter int unsigned W_END     = $clog2(N_ANDARES)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [W_END-1:0]     endereco,
    input  logic                 escrita,
    input  logic                 dado,
    input  logic [N_ANDARES-1:0] botoes,
    input  logic [W_END-1:0]     andar_atual,
    input  logic                 chegada,
    output logic [N_ANDARES-1:0] chamadas,
    output logic                 saida_endereco,
    output logic                 pendente,
    output logic [1:0]           direcao,
    output logic [W_END-1:0]     proximo_andar,
    output logic                 proximo_valido
);

    logic [N_ANDARES-1:0] chamadas_q, chamadas_d, mascara, chamadas_sel;
    logic                 saida_q, saida_d;
    logic                 andar_valido, aqui_atual;
    direction_t           direcao_q;
    logic [W_END-1:0]     proximo_q;
    logic                 valido_q;
    logic                 acima, abaixo, aqui;
    logic [W_END-1:0]     menor_acima, maior_abaixo;

    always_comb begin
        andar_valido = 1'b0;
        saida_d      = 1'b0;
        for (int unsigned i = 0; i < N_ANDARES; i++) begin
            mascara[i] = (andar_atual == W_END'(i));
            if (mascara[i]) andar_valido = 1'b1;
            // Set beats cancel/clear, so a press during arrival survives.
            if (botoes[i] || (escrita && dado && (endereco == W_END'(i)))) begin
                chamadas_d[i] = 1'b1;
            end else if ((escrita && !dado && (endereco == W_END'(i))) ||
                         (chegada && mascara[i])) begin
                chamadas_d[i] = 1'b0;
            end else begin
                chamadas_d[i] = chamadas_q[i];
            end
            if (!escrita && (endereco == W_END'(i))) saida_d = chamadas_q[i];
        end
        aqui_atual = |(chamadas_q & mascara);
        // While stopped the current floor is hidden, so targets are strictly above/below.
        chamadas_sel = (direcao_q == PARADO) ? (chamadas_q & ~mascara) : chamadas_q;
    end

    seletor_proximo_andar #(
        .N_ANDARES (N_ANDARES),
        .W_END     (W_END)
    ) u_seletor (
        .chamadas     (chamadas_sel),
        .andar_atual  (andar_atual),
        .acima        (acima),
        .abaixo       (abaixo),
        .aqui         (aqui),
        .menor_acima  (menor_acima),
        .maior_abaixo (maior_abaixo)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chamadas_q <= '0;
            saida_q    <= 1'b0;
        end else begin
            chamadas_q <= chamadas_d;
            saida_q    <= saida_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            direcao_q <= PARADO;
            proximo_q <= '0;
            valido_q  <= 1'b0;
        end else if (!andar_valido) begin
            direcao_q <= PARADO;
            valido_q  <= 1'b0;
        end else begin
            case (direcao_q)
                PARADO: begin
                    if (acima) begin
                        direcao_q <= SUBINDO;
                        proximo_q <= menor_acima;
                        valido_q  <= 1'b1;
                    end else if (abaixo) begin
                        direcao_q <= DESCENDO;
                        proximo_q <= maior_abaixo;
                        valido_q  <= 1'b1;
                    end else if (aqui_atual) begin
                        proximo_q <= andar_atual;
                        valido_q  <= 1'b1;
                    end else begin
                        valido_q  <= 1'b0;
                    end
                end
                SUBINDO: begin
                    if (acima || aqui) begin
                        proximo_q <= menor_acima;
                        valido_q  <= 1'b1;
                    end else if (abaixo) begin
                        direcao_q <= DESCENDO;
                        proximo_q <= maior_abaixo;
                        valido_q  <= 1'b1;
                    end else begin
                        direcao_q <= PARADO;
                        valido_q  <= 1'b0;
                    end
                end
                DESCENDO: begin
                    if (abaixo || aqui) begin
                        proximo_q <= maior_abaixo;
                        valido_q  <= 1'b1;
                    end else if (acima) begin
                        direcao_q <= SUBINDO;
                        proximo_q <= menor_acima;
                        valido_q  <= 1'b1;
                    end else begin
                        direcao_q <= PARADO;
                        valido_q  <= 1'b0;
                    end
                end
                default: begin
                    direcao_q <= PARADO;
                    valido_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chamadas       = chamadas_q;
    assign saida_endereco = saida_q;
    assign pendente       = |chamadas_q;
    assign direcao        = direcao_q;
    assign proximo_andar  = proximo_q;
    assign proximo_valido = valido_q;

endmodule
